// File: rtl/mod_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mod_pkg
// Brief   : Shared constants and FSM state encoding for pseudo-Mersenne
//           reduction modulo p = 2^W - C.
// Revision: 1.0 - initial release
// ============================================================================
package mod_pkg;

    localparam int W  = 256;
    localparam int CW = 34;
    localparam logic [CW-1:0] C = 34'h1000003D1;

    // Modulus carried at W+1 bits so it compares directly against the fold2 sum
    localparam logic [W:0] P_MOD = {1'b1, {W{1'b0}}} - {{(W + 1 - CW){1'b0}}, C};

    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] FOLD1 = 3'd1;
    localparam logic [STATE_W-1:0] FOLD2 = 3'd2;
    localparam logic [STATE_W-1:0] SUB   = 3'd3;
    localparam logic [STATE_W-1:0] HOLD  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/fold_mac.sv
`default_nettype none
// ============================================================================
// Module  : fold_mac
// Brief   : Combinational multiply-accumulate o_y = i_a + i_b * C used by
//           both fold passes of the pseudo-Mersenne reducer.
// Revision: 1.0 - initial release
// ============================================================================
module fold_mac
    import mod_pkg::*;
#(
    parameter int AW = 256,
    parameter int BW = 256,
    parameter int CONST_W = 34,
    parameter int OW = 290,
    parameter logic [CONST_W-1:0] FOLD_C = mod_pkg::C
) (
    input  logic [AW-1:0] i_a,
    input  logic [BW-1:0] i_b,
    output logic [OW-1:0] o_y
);

    // OW must hold the full a + b*C sum; both operands are widened before use
    assign o_y = OW'(i_a) + (OW'(i_b) * OW'(FOLD_C));

endmodule
`default_nettype wire

// File: rtl/pmersenne_reduce.sv
`default_nettype none
// ============================================================================
// Module  : pmersenne_reduce
// Brief   : Reduces a 2W-bit product modulo p = 2^W - C using two multiply-fold
//           passes and one conditional subtract, with valid/ready output.
// Revision: 1.0 - initial release
// ============================================================================
module pmersenne_reduce
    import mod_pkg::*;
#(
    parameter int W  = mod_pkg::W,
    parameter int CW = mod_pkg::CW,
    parameter logic [CW-1:0] C = mod_pkg::C
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] X,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   R,
    output logic           drop_err
);

    localparam logic [W:0] c_p_mod = {1'b1, {W{1'b0}}} - (W + 1)'(C);

    logic [STATE_W-1:0] r_state;
    logic [W-1:0]       r_hi;
    logic [W-1:0]       r_lo;
    logic [W+CW-1:0]    r_t1;
    logic [W:0]         r_t2;
    logic [W-1:0]       r_r;
    logic               r_out_valid;
    logic               r_drop_err;

    logic               w_in_ready;
    logic [W+CW-1:0]    w_t1;
    logic [W:0]         w_t2;
    logic [W-1:0]       w_r;

    assign w_in_ready = (r_state == IDLE);

    // First fold carries the W x CW multiply: t1 = lo + hi*C
    fold_mac #(
        .AW      (W),
        .BW      (W),
        .CONST_W (CW),
        .OW      (W + CW),
        .FOLD_C  (C)
    ) u_fold1 (
        .i_a (r_lo),
        .i_b (r_hi),
        .o_y (w_t1)
    );

    // Second fold: t2 = t1[W-1:0] + t1[W+CW-1:W]*C, bounded below 2^W + 2^(2CW)
    fold_mac #(
        .AW      (W),
        .BW      (CW),
        .CONST_W (CW),
        .OW      (W + 1),
        .FOLD_C  (C)
    ) u_fold2 (
        .i_a (r_t1[W-1:0]),
        .i_b (r_t1[W+CW-1:W]),
        .o_y (w_t2)
    );

    // t2 - p < p, so one conditional subtract lands in [0, p)
    assign w_r = (r_t2 >= c_p_mod) ? W'(r_t2 - c_p_mod) : r_t2[W-1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_hi        <= '0;
            r_lo        <= '0;
            r_t1        <= '0;
            r_t2        <= '0;
            r_r         <= '0;
            r_out_valid <= 1'b0;
            r_drop_err  <= 1'b0;
        end else begin
            if (in_valid && !w_in_ready) begin
                r_drop_err <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_hi    <= X[2*W-1:W];
                        r_lo    <= X[W-1:0];
                        r_state <= FOLD1;
                    end
                end
                FOLD1: begin
                    r_t1    <= w_t1;
                    r_state <= FOLD2;
                end
                FOLD2: begin
                    r_t2    <= w_t2;
                    r_state <= SUB;
                end
                SUB: begin
                    r_r         <= w_r;
                    r_out_valid <= 1'b1;
                    r_state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign R         = r_r;
    assign drop_err  = r_drop_err;

endmodule
`default_nettype wire

// File: tb/tb_pmersenne_reduce.sv
`default_nettype none
// ============================================================================
// Module  : tb_pmersenne_reduce
// Brief   : Self-checking bench for pmersenne_reduce; expected residues are
//           queued at accept and compared when the output handshake occurs.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pmersenne_reduce;

    localparam logic [511:0] c_p_wide = (512'd1 << 256) - 512'h1000003D1;
    localparam logic [255:0] c_p      = c_p_wide[255:0];

    logic         clock;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] X;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] R;
    logic         drop_err;

    int checks   = 0;
    int failures = 0;
    logic [255:0] sb[$];

    pmersenne_reduce dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (X),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .R         (R),
        .drop_err  (drop_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_word(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Reference residue by plain wide modulo, independent of the fold scheme
    function automatic logic [255:0] ref_mod(input logic [511:0] x);
        logic [511:0] q;
        q = x % c_p_wide;
        return q[255:0];
    endfunction

    task automatic send(input logic [511:0] x, input logic [255:0] e);
        int n = 0;
        while (!in_ready && n < 64) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) begin
            check_bit("send_timeout", in_ready, 1'b1);
        end else begin
            in_valid = 1'b1;
            X        = x;
            @(posedge clock);
            sb.push_back(e);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 200) begin
            @(negedge clock);
            n++;
        end
        check_bit("drain_timeout", (sb.size() == 0) && in_ready, 1'b1);
    endtask

    // Output monitor: the handshake completes at the next posedge
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_bit("unexpected_out_valid", out_valid, 1'b0);
            end else begin
                check_word("R", R, sb.pop_front());
                check_bit("R_below_p", R < c_p, 1'b1);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] x;
        logic [255:0] e;
        int           n;

        reset     = 1'b1;
        in_valid  = 1'b0;
        X         = '0;
        out_ready = 1'b0;
        #1;
        check_bit ("rst_in_ready",  in_ready,  1'b1);
        check_bit ("rst_out_valid", out_valid, 1'b0);
        check_word("rst_R",         R,         256'd0);
        check_bit ("rst_drop_err",  drop_err,  1'b0);
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Latency: accept at edge k, out_valid seen at edge k+4, in_ready back at k+5
        out_ready = 1'b1;
        @(negedge clock);
        in_valid = 1'b1;
        X        = '0;
        @(posedge clock);
        sb.push_back(256'd0);
        #1 in_valid = 1'b0;
        check_bit("lat_in_ready_k", in_ready, 1'b0);
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        check_bit("lat_ov_before_k3", out_valid, 1'b0);
        @(negedge clock);
        check_bit("lat_ov_at_k4",       out_valid, 1'b1);
        check_bit("lat_in_ready_at_k4", in_ready,  1'b0);
        @(negedge clock);
        check_bit("lat_in_ready_at_k5", in_ready,  1'b1);
        check_bit("lat_ov_dropped",     out_valid, 1'b0);

        // Boundary values
        send(c_p_wide,                256'd0);
        send(c_p_wide - 512'd1,       c_p - 256'd1);
        send(512'd1 << 256,           256'h1000003D1);
        send('1,                      256'h1000007A2000E90A0);
        send((512'd1 << 256) - 512'd1, 256'h1000003D0);
        wait_drain();

        // Backpressure: R held while out_ready is low
        out_ready = 1'b0;
        x = {16{32'hDEADBEEF}};
        e = ref_mod(x);
        send(x, e);
        n = 0;
        while (!out_valid && n < 16) begin
            @(negedge clock);
            n++;
        end
        check_bit("bp_out_valid", out_valid, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check_word("bp_R_stable",   R,         e);
            check_bit ("bp_valid_held", out_valid, 1'b1);
            check_bit ("bp_in_ready",   in_ready,  1'b0);
        end
        @(posedge clock);
        #1 out_ready = 1'b1;
        @(posedge clock);
        #1;
        check_bit("bp_idle_after_accept", in_ready, 1'b1);
        x = {8{64'h0123456789ABCDEF}};
        in_valid = 1'b1;
        X        = x;
        @(posedge clock);
        sb.push_back(ref_mod(x));
        #1 in_valid = 1'b0;
        check_bit("bp_next_accepted", in_ready, 1'b0);
        wait_drain();
        check_bit("drop_err_clear", drop_err, 1'b0);

        // Input pulsed during FOLD2 is dropped and flagged
        x = {16{32'h5A5AA5A5}};
        send(x, ref_mod(x));
        @(posedge clock);
        #1;
        in_valid = 1'b1;
        X        = '1;
        @(posedge clock);
        #1 in_valid = 1'b0;
        check_bit("drop_err_set", drop_err, 1'b1);
        wait_drain();
        check_bit("drop_err_sticky", drop_err, 1'b1);

        // Reset during FOLD1 aborts with no output
        x = {16{32'h13579BDF}};
        send(x, ref_mod(x));
        reset = 1'b1;
        #1;
        check_bit("mid_rst_out_valid", out_valid, 1'b0);
        check_bit("mid_rst_in_ready",  in_ready,  1'b1);
        check_bit("mid_rst_drop_err",  drop_err,  1'b0);
        sb.delete();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (8) @(negedge clock);
        check_bit("mid_rst_no_stale", out_valid, 1'b0);

        // Random operands against the reference model
        for (int i = 0; i < 10000; i++) begin
            for (int j = 0; j < 16; j++) begin
                x[j*32 +: 32] = $urandom;
            end
            if (i % 16 == 0) begin
                x[511:256] = '0;
            end else if (i % 16 == 1) begin
                x = c_p_wide + 512'($urandom);
            end
            send(x, ref_mod(x));
        end
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
